// File: rtl/switch_out_arbiter_if.sv
// switch_out_arbiter_if: request/data bus between the switch ingress ports
// and one output arbiter, plus the egress valid/ready handshake.
//   port_req  : per-port request, bit i from ingress port i
//   pkt_dst   : per-port head-packet target, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   pkt_data  : per-port head packet, slice i = [i*PACKET_WIDTH +: PACKET_WIDTH]
//   out_ready : downstream accepts data_out this cycle
//   grant     : one-hot single-cycle grant back to the ports
//   valid_out : data_out holds a packet
//   data_out  : captured packet
// master = port/downstream side, slave = arbiter side.
interface switch_out_arbiter_if #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int PACKET_WIDTH = 16
);
  logic [NUM_PORTS-1:0]              port_req;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   pkt_dst;
  logic [NUM_PORTS*PACKET_WIDTH-1:0] pkt_data;
  logic                              out_ready;
  logic [NUM_PORTS-1:0]              grant;
  logic                              valid_out;
  logic [PACKET_WIDTH-1:0]           data_out;

  modport master (
    output port_req, pkt_dst, pkt_data, out_ready,
    input  grant, valid_out, data_out
  );

  modport slave (
    input  port_req, pkt_dst, pkt_data, out_ready,
    output grant, valid_out, data_out
  );
endinterface

// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter: per-output round-robin arbiter and single-entry egress
// register. Picks one ingress port whose head packet targets DEST_ADDR,
// issues a one-cycle grant, and captures that packet into data_out.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : switch_out_arbiter_if.slave (port_req, pkt_dst, pkt_data,
//            out_ready in; grant, valid_out, data_out out)
//   pkt_cnt: delivered-packet counter, present only when SWITCH_OUT_PKT_CNT_EN
//            is defined
// Optional feature macro: SWITCH_OUT_PKT_CNT_EN
//
// state | meaning
// ARB   | wait for an eligible request with a free output slot, pick winner
// GRANT | grant pulse to winner; capture its packet if it still requests
// GAP   | dead cycle; the granted port's request is still visible here
module switch_out_arbiter #(
  parameter int              NUM_PORTS    = 4,
  parameter int              ADDR_WIDTH   = 4,
  parameter int              PACKET_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  switch_out_arbiter_if.slave  bus
`ifdef SWITCH_OUT_PKT_CNT_EN
  ,
  output logic [15:0]          pkt_cnt
`endif
);

  typedef enum logic [1:0] {ARB, GRANT, GAP} state_t;

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [1:0]              winner;
  logic [NUM_PORTS-1:0]    grant_q;
  logic                    valid_q;
  logic [PACKET_WIDTH-1:0] data_q;

  logic [ADDR_WIDTH-1:0]   dst_a  [NUM_PORTS];
  logic [PACKET_WIDTH-1:0] data_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]    elig;
  logic [1:0]              pick;
  logic                    slot_free;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst_a[i]  = bus.pkt_dst[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_a[i] = bus.pkt_data[i*PACKET_WIDTH +: PACKET_WIDTH];
      elig[i]   = bus.port_req[i] && (dst_a[i] == DEST_ADDR);
    end
  end

  assign slot_free = !valid_q || bus.out_ready;

  // Round-robin search starting at rr_ptr; 2-bit index wraps naturally.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_ptr  <= 2'd0;
      winner  <= 2'd0;
      grant_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // Delivery clears valid; a capture in GRANT below overrides it.
      if (valid_q && bus.out_ready) valid_q <= 1'b0;

      case (state)
        ARB: begin
          if (|elig && slot_free) begin
            winner  <= pick;
            grant_q <= NUM_PORTS'(1) << pick;
            state   <= GRANT;
          end
        end
        GRANT: begin
          grant_q <= '0;
          // Port withdrew its request during the grant: abort, no capture.
          if (bus.port_req[winner]) begin
            data_q  <= data_a[winner];
            valid_q <= 1'b1;
            rr_ptr  <= winner + 2'd1;
          end
          state <= GAP;
        end
        GAP: state <= ARB;
        default: begin
          grant_q <= '0;
          state   <= ARB;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

`ifdef SWITCH_OUT_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         pkt_cnt <= 16'd0;
    else if (valid_q && bus.out_ready)  pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_switch_out_arbiter.sv
module tb_switch_out_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_out_arbiter_if bus ();

`ifdef SWITCH_OUT_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  switch_out_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SWITCH_OUT_PKT_CNT_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: next round-robin start port and last captured packet.
  int          m_ptr = 0;
  logic [15:0] m_data = 16'h0;
  int          m_deliv = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(input int i, input logic req, input logic [3:0] dst,
                          input logic [15:0] data);
    bus.port_req[i]        = req;
    bus.pkt_dst[i*4 +: 4]  = dst;
    bus.pkt_data[i*16 +: 16] = data;
  endtask

  task automatic clear_ports();
    bus.port_req = 4'b0;
    bus.pkt_dst  = 16'h0;
    bus.pkt_data = 64'h0;
  endtask

  // Winner by the round-robin rule: first eligible port from m_ptr upward.
  function automatic int model_winner(input logic [3:0] req, input logic [15:0] dst);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (m_ptr + k) % 4;
      if (req[p] && dst[p*4 +: 4] == 4'h1) return p;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr  = 0;
    m_data = 16'h0;
  endtask

  initial begin
    clear_ports();
    bus.out_ready = 1'b1;
    #22;
    check("reset_grant", {28'h0, bus.grant}, 32'h0);
    check("reset_valid", {31'h0, bus.valid_out}, 32'h0);
    check("reset_data", {16'h0, bus.data_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on port 2.
    set_port(2, 1'b1, 4'h1, 16'hA5C1);
    step();
    check("single_grant", {28'h0, bus.grant}, 32'h4);
    step();
    check("single_grant_gap", {28'h0, bus.grant}, 32'h0);
    check("single_valid", {31'h0, bus.valid_out}, 32'h1);
    check("single_data", {16'h0, bus.data_out}, 32'hA5C1);
    clear_ports();
    step();
    check("single_drained", {31'h0, bus.valid_out}, 32'h0);

    // Round-robin with all four ports requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 4'h1, 16'hB000 + 16'(i));
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c % 3 == 1) begin
        check("rr_grant", {28'h0, bus.grant}, 32'(1) << m_ptr);
        m_data = 16'hB000 + 16'(m_ptr);
        m_ptr  = (m_ptr + 1) % 4;
      end else begin
        check("rr_nogrant", {28'h0, bus.grant}, 32'h0);
      end
      if (c % 3 == 2) check("rr_data", {16'h0, bus.data_out}, {16'h0, m_data});
    end
    clear_ports();
    step();

    // Destination filter: port 1 targets another output.
    set_port(1, 1'b1, 4'h2, 16'hDEAD);
    for (int c = 0; c < 20; c++) begin
      step();
      check("filter_grant", {28'h0, bus.grant}, 32'h0);
      check("filter_valid", {31'h0, bus.valid_out}, 32'h0);
    end
    clear_ports();

    // Backpressure: capture 1234, hold out_ready low while port 3 waits.
    bus.out_ready = 1'b0;
    set_port(0, 1'b1, 4'h1, 16'h1234);
    step();
    check("bp_grant0", {28'h0, bus.grant}, 32'h1);
    step();
    check("bp_data", {16'h0, bus.data_out}, 32'h1234);
    m_ptr = 1;
    clear_ports();
    set_port(3, 1'b1, 4'h1, 16'h5678);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_grant", {28'h0, bus.grant}, 32'h0);
      check("bp_hold_valid", {31'h0, bus.valid_out}, 32'h1);
      check("bp_hold_data", {16'h0, bus.data_out}, 32'h1234);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_grant", {28'h0, bus.grant}, 32'h8);
    step();
    check("bp_release_data", {16'h0, bus.data_out}, 32'h5678);
    m_ptr = 0;
    clear_ports();
    step();

    // Abort: port 2 withdraws during its grant; pointer must not advance.
    set_port(2, 1'b1, 4'h1, 16'hCAFE);
    step();
    check("abort_grant", {28'h0, bus.grant}, 32'h4);
    bus.port_req[2] = 1'b0;
    step();
    check("abort_valid", {31'h0, bus.valid_out}, 32'h0);
    check("abort_data", {16'h0, bus.data_out}, 32'h5678);
    step();
    set_port(2, 1'b1, 4'h1, 16'hCAFE);
    set_port(3, 1'b1, 4'h1, 16'hBEEF);
    step();
    check("abort_ptr_kept", {28'h0, bus.grant}, 32'h4);
    step();
    check("abort_retry_data", {16'h0, bus.data_out}, 32'hCAFE);
    clear_ports();
    step();

    // Reset asserted mid-grant.
    set_port(1, 1'b1, 4'h1, 16'h7777);
    step();
    check("rst_pre_grant", {28'h0, bus.grant}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_grant", {28'h0, bus.grant}, 32'h0);
    check("rst_mid_valid", {31'h0, bus.valid_out}, 32'h0);
    check("rst_mid_data", {16'h0, bus.data_out}, 32'h0);
    clear_ports();
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_data = 16'h0;
    step();

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  req;
      logic [15:0] dst;
      logic [63:0] data;
      int          w;
      logic        abort;
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        dst[i*4 +: 4]   = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom_range(0, 15));
        data[i*16 +: 16] = 16'($urandom);
      end
      bus.port_req = req;
      bus.pkt_dst  = dst;
      bus.pkt_data = data;
      w = model_winner(req, dst);
      step();
      if (w < 0) begin
        check("rnd_nogrant", {28'h0, bus.grant}, 32'h0);
        clear_ports();
        step();
        check("rnd_idle_valid", {31'h0, bus.valid_out}, 32'h0);
      end else begin
        check("rnd_grant", {28'h0, bus.grant}, 32'(1) << w);
        abort = ($urandom_range(0, 3) == 0);
        if (abort) bus.port_req[w] = 1'b0;
        step();
        if (!abort) begin
          m_data = data[w*16 +: 16];
          m_ptr  = (w + 1) % 4;
          m_deliv++;
        end
        check("rnd_valid", {31'h0, bus.valid_out}, {31'h0, !abort});
        check("rnd_data", {16'h0, bus.data_out}, {16'h0, m_data});
        check("rnd_gap_grant", {28'h0, bus.grant}, 32'h0);
        clear_ports();
        step();
      end
    end
    step();
    check("rnd_end_valid", {31'h0, bus.valid_out}, 32'h0);

`ifdef SWITCH_OUT_PKT_CNT_EN
    check("pkt_cnt", {16'h0, pkt_cnt}, 32'(m_deliv));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/switch_out_arbiter.md
Name: switch_out_arbiter

Overview:
- Per-output-port arbitration and egress stage; one instance per switch output.
- Sits directly downstream of the four switch_port instances and consumes their port_req, pkt_dst and fifo_data_out.
- Selects one requesting port whose destination matches this output using round-robin, and returns a single-cycle grant.
- Captures the granted packet into a single-entry output register with a valid/ready handshake.

Parameters:
- NUM_PORTS, 4, number of ingress ports; logic is written for exactly 4.
- ADDR_WIDTH, 4, address width; equals packet_pkg::ADDR_WIDTH.
- PACKET_WIDTH, 16, packet width {data,target,source}; equals packet_pkg::PACKET_WIDTH.
- DEST_ADDR, 4'h1, target address served by this output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- port_req  in  4  request per ingress port; bit i comes from port i.
- pkt_dst  in  4*ADDR_WIDTH  target of each port's head packet; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- pkt_data  in  4*PACKET_WIDTH  head packet of each port FIFO; slice i as above.
- out_ready  in  1  downstream accepts data_out this cycle.
- grant  out  4  one-hot grant pulse back to the ports. Top level ORs the grants of all arbiters per port.
- valid_out  out  1  data_out holds a packet.
- data_out  out  PACKET_WIDTH  captured packet.

Behaviour:
- Reset (async, immediate): state=ARB, rr_ptr=0, winner=0, grant=4'b0, valid_out=0, data_out=0.
- Eligibility: elig[i] = port_req[i] && (pkt_dst slice i == DEST_ADDR).
- Slot free: slot_free = !valid_out || out_ready.
- grant is decoded from registered state/winner only, never combinationally from inputs. This is required because the port pops its FIFO on the grant edge.
- FSM states: ARB, GRANT, GAP.
  - ARB: if |elig && slot_free, then winner <= first eligible index found searching rr_ptr, rr_ptr+1, ... mod 4, and next state is GRANT. Otherwise stay in ARB.
  - GRANT: grant = 1 << winner, for exactly one cycle. At the closing edge:
    - If port_req[winner] is still 1: data_out <= pkt_data[winner], valid_out <= 1, rr_ptr <= (winner+1) mod 4.
    - Else: abort; no capture, rr_ptr unchanged.
    - Next state is GAP in both cases.
  - GAP: grant=0. Requests are ignored because the granted port still shows port_req high during GRANT. Next state is ARB.
- Output handshake:
  - valid_out && out_ready at an edge clears valid_out, unless a GRANT capture occurs at the same edge; in that case valid_out stays 1 and data_out takes the new packet.
  - data_out is stable while valid_out && !out_ready.
- Latency: eligible request seen in cycle N -> grant in cycle N+1 -> valid_out in cycle N+2.
- Throughput: maximum 1 packet per 3 cycles.
- Backpressure: while valid_out=1 and out_ready=0, the FSM stays in ARB and no grant is issued.
- Non-matching requests (pkt_dst != DEST_ADDR) never cause a grant from this instance.
- rr_ptr wraps 3 -> 0.
- Reset mid-GRANT: grant drops asynchronously; the packet is neither captured nor considered delivered.

Optional Feature:
- Macro: SWITCH_OUT_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_cnt [15:0], reset 0.
  - Increments by 1 on every edge where valid_out && out_ready; wraps 16'hFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: port_req=4'b0100, pkt_dst slice 2=4'h1, pkt_data slice 2=16'hA5C1, out_ready=1.
  - Required: grant=4'b0100 for exactly 1 cycle at N+1.
  - Required: valid_out=1 with data_out=16'hA5C1 at N+2, and grant=0 during GAP.
- Round-robin fairness: all 4 ports request DEST_ADDR continuously, out_ready=1.
  - Required grant order: 0001, 0010, 0100, 1000, 0001, with grants spaced 3 cycles apart.
- Destination filter: port 1 requests with pkt_dst=4'h2.
  - Required: grant stays 0 and valid_out stays 0 for 20 cycles.
- Backpressure: capture 16'h1234, then hold out_ready=0 for 5 cycles while port 3 requests.
  - Required: data_out holds 16'h1234 and no grant is issued.
  - Required: once out_ready=1, grant=4'b1000 issues on the next cycle.
- Abort and reset:
  - Drop port_req[winner] during GRANT -> valid_out stays 0 and rr_ptr is unchanged.
  - Assert rst_n=0 mid-GRANT -> grant=0 and valid_out=0 immediately.
- Counter (SWITCH_OUT_PKT_CNT_EN): 3 deliveries -> pkt_cnt=3. Preload to 16'hFFFF via forced delivery count -> next delivery gives pkt_cnt=0.
